// File: rtl/fcvt_sched.sv
// Two-requester round-robin scheduler around a shared float<->int conversion pipeline.
// Optional FCVT_SCHED_FLAG_EN adds res_ovf, flagging saturated ftoi results.

module fcvt_ftoi (
    input  logic [31:0] a,
    output logic [31:0] y
);
    logic [7:0]  e;
    logic [32:0] x2;
    logic [31:0] mag;

    // x2 holds the magnitude with one extra fraction bit; adding that bit rounds ties away from zero.
    always_comb begin
        e   = a[30:23];
        x2  = '0;
        mag = '0;
        y   = '0;
        if (e >= 8'd158) begin
            y = 32'h8000_0000;
        end else if (e >= 8'd126) begin
            if (e >= 8'd149)
                x2 = {9'd0, 1'b1, a[22:0]} << (e - 8'd149);
            else
                x2 = {9'd0, 1'b1, a[22:0]} >> (8'd149 - e);
            mag = x2[32:1] + {31'd0, x2[0]};
            y   = a[31] ? -mag : mag;
        end
    end
endmodule

module fcvt_itof (
    input  logic [31:0] a,
    output logic [31:0] y
);
    logic [31:0] mag;
    logic [4:0]  msb;
    logic [30:0] norm;
    logic        rnd;
    logic [30:0] body;

    always_comb begin
        mag = a[31] ? -a : a;
        msb = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i])
                msb = 5'(i);
        end
        norm = 31'(mag << (5'd31 - msb));
        // Round to nearest even: guard bit set and either sticky bits or an odd lsb.
        rnd  = norm[7] & ((|norm[6:0]) | norm[8]);
        body = {8'd127 + 8'(msb), norm[30:8]} + 31'(rnd);
        y    = (a == 32'd0) ? 32'd0 : {a[31], body};
    end
endmodule

module fcvt_sched #(
    parameter int LATENCY = 2,
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [31:0] req0_src,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [31:0] req1_src,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_id,
`ifdef FCVT_SCHED_FLAG_EN
    output logic        res_ovf,
`endif
    output logic [31:0] res_data
);
    logic        ptr_reg;
    logic        grant0, grant1, stall, accept;
    logic        sel_op;
    logic [31:0] sel_src, ftoi_res, itof_res, conv_data;

    logic        v_reg  [LATENCY];
    logic        id_reg [LATENCY];
    logic [31:0] d_reg  [LATENCY];
`ifdef FCVT_SCHED_FLAG_EN
    logic        conv_ovf;
    logic        o_reg  [LATENCY];
    assign conv_ovf = ~sel_op & (sel_src[30:23] >= 8'd158);
    assign res_ovf  = o_reg[LATENCY-1];
`endif

    assign res_valid = v_reg[LATENCY-1];
    assign res_id    = id_reg[LATENCY-1];
    assign res_data  = d_reg[LATENCY-1];
    assign stall     = res_valid & ~res_ready;

    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~ptr_reg);
        grant1 = req1_valid & (~req0_valid |  ptr_reg);
    end

    assign req0_ready = grant0 & ~stall;
    assign req1_ready = grant1 & ~stall;
    assign accept     = req0_ready | req1_ready;

    assign sel_op    = grant1 ? req1_op  : req0_op;
    assign sel_src   = grant1 ? req1_src : req0_src;
    assign conv_data = sel_op ? itof_res : ftoi_res;

    fcvt_ftoi u_ftoi (.a(sel_src), .y(ftoi_res));
    fcvt_itof u_itof (.a(sel_src), .y(itof_res));

    // Pointer hands priority to the requester that was not just served.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ptr_reg <= RR_INIT;
        else if (accept)
            ptr_reg <= ~grant1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_reg[0]  <= 1'b0;
            id_reg[0] <= 1'b0;
            d_reg[0]  <= '0;
`ifdef FCVT_SCHED_FLAG_EN
            o_reg[0]  <= 1'b0;
`endif
        end else if (!stall) begin
            v_reg[0]  <= accept;
            id_reg[0] <= grant1;
            d_reg[0]  <= conv_data;
`ifdef FCVT_SCHED_FLAG_EN
            o_reg[0]  <= conv_ovf;
`endif
        end
    end

    // Later stages only carry results; a stall freezes the whole pipe.
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    v_reg[gi]  <= 1'b0;
                    id_reg[gi] <= 1'b0;
                    d_reg[gi]  <= '0;
`ifdef FCVT_SCHED_FLAG_EN
                    o_reg[gi]  <= 1'b0;
`endif
                end else if (!stall) begin
                    v_reg[gi]  <= v_reg[gi-1];
                    id_reg[gi] <= id_reg[gi-1];
                    d_reg[gi]  <= d_reg[gi-1];
`ifdef FCVT_SCHED_FLAG_EN
                    o_reg[gi]  <= o_reg[gi-1];
`endif
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_fcvt_sched.sv
// Scoreboard bench for fcvt_sched: expected results queued at acceptance, checked on delivery.
module tb_fcvt_sched;
    localparam int LAT = 2;
    localparam int NV  = 16;

    typedef struct packed {
        logic        op;
        logic [31:0] src;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic        id;
        logic        ovf;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0_valid = 1'b0, req0_op = 1'b0;
    logic [31:0] req0_src = '0;
    logic        req1_valid = 1'b0, req1_op = 1'b0;
    logic [31:0] req1_src = '0;
    logic        res_ready = 1'b0;
    logic        req0_ready, req1_ready, res_valid, res_id;
    logic [31:0] res_data;
`ifdef FCVT_SCHED_FLAG_EN
    logic        res_ovf;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    fcvt_sched #(.LATENCY(LAT), .RR_INIT(1'b0)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_src(req0_src),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_src(req1_src),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
`ifdef FCVT_SCHED_FLAG_EN
        .res_ovf(res_ovf),
`endif
        .res_data(res_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // op, operand, expected result, expected saturation flag
    function automatic vec_t vec(input int i);
        case (i)
            0:  return {1'b0, 32'h4020_0000, 32'h0000_0003, 1'b0};
            1:  return {1'b0, 32'hC020_0000, 32'hFFFF_FFFD, 1'b0};
            2:  return {1'b0, 32'h3F00_0000, 32'h0000_0001, 1'b0};
            3:  return {1'b0, 32'h3E80_0000, 32'h0000_0000, 1'b0};
            4:  return {1'b0, 32'h4F00_0000, 32'h8000_0000, 1'b1};
            5:  return {1'b0, 32'hCF80_0000, 32'h8000_0000, 1'b1};
            6:  return {1'b1, 32'h0000_0001, 32'h3F80_0000, 1'b0};
            7:  return {1'b1, 32'h8000_0000, 32'hCF00_0000, 1'b0};
            8:  return {1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
            9:  return {1'b0, 32'h3FC0_0000, 32'h0000_0002, 1'b0};
            10: return {1'b0, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0};
            11: return {1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0};
            12: return {1'b1, 32'h0100_0001, 32'h4B80_0000, 1'b0};
            13: return {1'b1, 32'h0100_0003, 32'h4B80_0002, 1'b0};
            14: return {1'b0, 32'h3FBF_FFFF, 32'h0000_0001, 1'b0};
            default: return {1'b0, 32'hBF00_0000, 32'hFFFF_FFFF, 1'b0};
        endcase
    endfunction

    always @(negedge clk) begin
        if (rstn && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("res_id", 32'(res_id), 32'(mon_e.id));
                chk("res_data", res_data, mon_e.data);
`ifdef FCVT_SCHED_FLAG_EN
                chk("res_ovf", 32'(res_ovf), 32'(mon_e.ovf));
`endif
                $display("result id=%0d data=%h expected id=%0d data=%h ovf=%0d",
                         res_id, res_data, mon_e.id, mon_e.data, mon_e.ovf);
            end
        end
    end

    task automatic send(input bit port, input int idx);
        vec_t v = vec(idx);
        bit   got = 1'b0;
        if (port) begin
            req1_valid = 1'b1; req1_op = v.op; req1_src = v.src;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_src = v.src;
        end
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) begin
                chk("idle_ready", 32'(port ? req0_ready : req1_ready), 32'd0);
                sb.push_back({port, v.ovf, v.res});
                got = 1'b1;
                $display("accept port=%0d op=%0d src=%h", port, v.op, v.src);
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!got)
            chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++)
            @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int   n;
        int   c0;
        vec_t v0, v1;

        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_data", res_data, 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
`ifdef FCVT_SCHED_FLAG_EN
        chk("rst_ovf", 32'(res_ovf), 32'd0);
`endif
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // First-result latency
        send(1'b0, 0);
        n = 1;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(LAT));
        wait_drain();

        // All vectors back to back on requester 1
        c0 = cyc;
        for (int i = 0; i < NV; i++)
            send(1'b1, i);
        chk("throughput", 32'(cyc - c0), 32'(NV));
        wait_drain();

        // Round-robin from a fresh reset
        rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            v0 = vec(k);
            v1 = vec(k + 6);
            req0_valid = 1'b1; req0_op = v0.op; req0_src = v0.src;
            req1_valid = 1'b1; req1_op = v1.op; req1_src = v1.src;
            @(negedge clk);
            chk("rr_grant1", 32'(req1_ready), 32'(k % 2));
            chk("rr_grant0", 32'(req0_ready), 32'((k + 1) % 2));
            if (req0_ready) sb.push_back({1'b0, v0.ovf, v0.res});
            if (req1_ready) sb.push_back({1'b1, v1.ovf, v1.res});
            $display("rr cycle=%0d ready0=%0d ready1=%0d", k, req0_ready, req1_ready);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain();

        // Full pipeline held by res_ready low
        res_ready = 1'b0;
        for (int i = 0; i < LAT; i++)
            send(1'b0, 1 + i);
        v1 = vec(9);
        req1_valid = 1'b1; req1_op = v1.op; req1_src = v1.src;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_ready0", 32'(req0_ready), 32'd0);
            chk("stall_ready1", 32'(req1_ready), 32'd0);
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_data", res_data, sb[0].data);
            chk("stall_id", 32'(res_id), 32'(sb[0].id));
            $display("stall cycle=%0d data=%h", k, res_data);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("release_ready1", 32'(req1_ready), 32'd1);
        if (req1_ready) sb.push_back({1'b1, v1.ovf, v1.res});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_drain();

        // Reset with operations in flight
        for (int i = 0; i < LAT; i++)
            send(1'b0, 10 + i);
        rstn = 1'b0;
        #1;
        chk("rst_flight_valid", 32'(res_valid), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int k = 0; k < 2 * LAT + 2; k++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(res_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(1'b1, 5);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
